multicycle_adder: RTL and testbench

Parametrised multi-cycle ripple adder: a WIDTH-bit sum is computed SLICE bits per clock, least-significant slice first, with the carry held in a register between slices. It generalises the team's 4-bit combinational adder to arbitrary width with valid/ready handshakes on input and output. It sits as a datapath unit behind a producer/consumer pair where area matters more than latency.

---
 rtl/multicycle_adder_pkg.sv | 23 ++
 rtl/multicycle_adder_slice_adder.sv | 25 ++
 rtl/multicycle_adder.sv | 143 ++++++++++++++
 tb/tb_multicycle_adder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_adder_pkg.sv
// ============================================================================
// Module   : multicycle_adder_pkg
// Brief    : Shared types and helpers for the multi-cycle ripple adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the slice index counter; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_adder_slice_adder.sv
// ============================================================================
// Module   : slice_adder
// Brief    : Combinational SLICE-bit adder exposing the carry into its MSB.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slice_adder #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
  // The carry into the top bit is recovered from that bit's own sum equation.
  assign c_msb     = s[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];

endmodule

`default_nettype wire

// File: rtl/multicycle_adder.sv
// ============================================================================
// Module   : multicycle_adder
// Brief    : WIDTH-bit adder computed SLICE bits per clock, LSB slice first,
//            with valid/ready handshakes. Define MULTICYCLE_ADDER_SUB_EN to
//            add the Sub port (A - B).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef MULTICYCLE_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = int'(idx_width(NSLICE));
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [SLICE-1:0]  w_a_slice;
  logic [SLICE-1:0]  w_b_slice;
  logic [SLICE-1:0]  w_s;
  logic              w_cout;
  logic              w_cmsb;

  assign w_a_slice = a_q[int'(idx_q)*SLICE +: SLICE];
  assign w_b_slice = b_q[int'(idx_q)*SLICE +: SLICE];

  slice_adder #(
    .SLICE (SLICE)
  ) u_slice_adder (
    .a     (w_a_slice),
    .b     (w_b_slice),
    .cin   (carry_q),
    .s     (w_s),
    .cout  (w_cout),
    .c_msb (w_cmsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          idx_d   = '0;
          state_d = RUN;
`ifdef MULTICYCLE_ADDER_SUB_EN
          // Two's-complement subtract: invert B and inject the +1 as carry-in.
          if (Sub) begin
            b_d     = ~B;
            carry_d = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*SLICE +: SLICE] = w_s;
        carry_d = w_cout;
        if (idx_q == IDX_LAST) begin
          cout_d  = w_cout;
          ovf_d   = w_cmsb ^ w_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // in_ready is held low while rst is asserted, even though the state is IDLE.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_adder.sv
// ============================================================================
// Module   : tb_multicycle_adder
// Brief    : Scoreboard bench for multicycle_adder (WIDTH=16, SLICE=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        Sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Sum;
  logic        Cout;
  logic        Ovf;

  int nchecks = 0;
  int nerr    = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  multicycle_adder #(
    .WIDTH (16),
    .SLICE (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
`ifdef MULTICYCLE_ADDER_SUB_EN
    .Sub       (Sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the full word, {Sum, Cout, Ovf}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic sub);
    logic [15:0] bb;
    logic [16:0] full;
    logic        ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
    ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
    return {full[15:0], full[16], ovf};
  endfunction

  // Monitor: compares every result the consumer takes against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        check("result", {14'd0, Sum, Cout, Ovf}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, input int hold);
    int n;
    logic [17:0] held;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
    exp_q.push_back(model(a, b, cin, sub));
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("latency", 32'(n), 32'd4);
    if (!out_valid) return;
    for (int i = 0; i < hold; i++) begin
      held = {Sum, Cout, Ovf};
      in_valid = ~in_valid;
      A = 16'($urandom); B = 16'($urandom);
      @(posedge clk); #1;
      check("hold_stable", {14'd0, Sum, Cout, Ovf}, {14'd0, held});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic sub_r;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_outputs", {14'd0, Sum, Cout, Ovf}, 32'd0);
    rst = 1'b0;
    #1;
    check("first_idle_in_ready", {31'd0, in_ready}, 32'd1);

    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0);
    do_op(16'h0F0F, 16'h1234, 1'b1, 1'b0, 5);

    // Abort after two RUN cycles; no result may appear.
    A = 16'hAAAA; B = 16'h5555; Cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_in_ready_in_rst", {31'd0, in_ready}, 32'd0);
    check("abort_outputs", {14'd0, Sum, Cout, Ovf}, 32'd0);
    rst = 1'b0;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_out_valid", 32'(seen), 32'd0);
    @(posedge clk); #1;
    do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);

`ifdef MULTICYCLE_ADDER_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1);
`endif

    for (int k = 0; k < 25; k++) begin
`ifdef MULTICYCLE_ADDER_SUB_EN
      sub_r = 1'($urandom);
`else
      sub_r = 1'b0;
`endif
      do_op(16'($urandom), 16'($urandom), 1'($urandom), sub_r, int'($urandom_range(0, 3)));
    end

    repeat (2) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

`default_nettype wire
